dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, word-addressed data memory between two byte-addressed requesters: port 0 = core LSU, port 1 = loader/debug.
//  Handles byte/half/word accesses: sub-word stores become read-modify-write on the word; loads return the zero-extended lane.
//  Sits between requesters and data_mem: drives its en/wr_addr/din, consumes its async-read dout.
// PARAMETERS
//  DATA_WIDTH     32  memory word width; fixed at 32 (byte lanes = 4)
//  ADDRESS_WIDTH  32  requester byte-address width; memory word index = addr[ADDRESS_WIDTH-1:2]
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   asynchronous, active-high reset
//  reqN_valid     in   1   N in {0,1}: request present; hold stable until accepted
//  reqN_ready     out  1   request accepted this cycle (valid && ready = handshake)
//  reqN_we        in   1   1 = store, 0 = load
//  reqN_size      in   2   0 byte, 1 half, 2 word; 3 is treated as word
//  reqN_addr      in   32  byte address
//  reqN_wdata     in   32  store data, in low bits (byte [7:0], half [15:0])
//  rspN_valid     out  1   one-cycle response pulse to the port that issued the request
//  rspN_rdata     out  32  load data, zero-extended; 0 for stores/errors
//  rspN_err       out  1   misaligned access; valid with rspN_valid
//  mem_en         out  1   data memory write enable
//  mem_addr       out  32  data memory word index
//  mem_din        out  32  data memory write word
//  mem_dout       in   32  data memory read word (combinational from mem_addr)
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Exactly one transaction in flight.
//  IDLE: ready asserted combinationally to at most one valid port (arbitration below).
//   On handshake: latch port id, we, size, addr, wdata; go ACCESS.
//  ACCESS: mem_addr = latched addr>>2. Misaligned = (half && addr[0]) || (word && addr[1:0]!=0).
//   Aligned store: mem_en=1; mem_din = mem_dout with the addressed lane(s) replaced by wdata.
//   Aligned load: capture lane addr[1:0] (byte) / addr[1] (half) / full word, zero-extend.
//   Misaligned: mem_en=0; record err=1. Go RESP.
//  RESP: rspN_valid=1 for the latched port only, with rdata/err; go IDLE.
//  Latency: handshake in cycle T -> memory write at edge ending T+1 -> rsp_valid in T+2.
//  Throughput: one transaction per 3 cycles; no ready during ACCESS/RESP.
//  mem_en is 1 only in ACCESS for an aligned store; mem_addr/mem_din are 0 outside ACCESS.
//  Outputs idle at 0 outside their states; rdata/err registered, cleared on the next handshake.
//  Reset (any time, async): state=IDLE, all latched fields, rsp_*, rr pointer = 0; an in-flight
//   write whose ACCESS edge has not occurred is dropped; no rsp is issued for it.
//  Both valid in same IDLE cycle: winner chosen per CONFIGURATION; loser keeps valid, waits.
//  A valid dropped before handshake is simply not served (protocol violation, not checked).
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin; 1-bit last_grant reg (reset 0 = port 0 last, so port 1
//   wins first contention); updated on every handshake; a lone requester always wins.
//  Undefined: fixed priority, port 0 always wins; last_grant not instantiated.
// STRUCTURE
//  Package dmem_pkg: size_t enum {SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2}, state_t enum
//   {S_IDLE, S_ACCESS, S_RESP}, localparam NUM_PORTS=2.
//  Sub-module dmem_lane_merge (combinational): inputs word, wdata, addr[1:0], size;
//   outputs merged store word, extracted load data, misaligned flag.
// TESTING
//  1 Word store p0 addr 0x10 data 0xDEADBEEF, then load word 0x10 -> mem[4]=0xDEADBEEF, rdata 0xDEADBEEF, rsp at T+2.
//  2 Word 0x11223344 at 0x20; byte store 0xAA at 0x22 -> mem[8]=0x11AA3344; half load 0x22 -> 0x000011AA.
//  3 Half load at 0x21 and word store at 0x26 -> rsp_err=1, rdata=0, mem_en never asserted, memory unchanged.
//  4 Both ports valid each IDLE for 4 txns: RR_EN -> grants 1,0,1,0; undefined -> 0,0,0,0 while p0 stays valid.
//  5 Assert rst in ACCESS of a store to 0x30 (before edge) -> mem[12] unchanged, no rsp, FSM IDLE, ready next cycle.
//  6 p1 alone valid under fixed priority -> accepted in first IDLE cycle; rsp1_valid only, rsp0_valid stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states, port count.
package dmem_pkg;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane helper: merges sub-word store data into a word, extracts zero-extended
// load lanes, and flags misaligned half/word accesses. Size 3 behaves as word.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  always_comb begin
    merged_o     = word_i;
    load_o       = 32'd0;
    misaligned_o = 1'b0;
    case (size_t'(size_i))
      SZ_BYTE: begin
        merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {24'd0, word_i[{addr_i, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        misaligned_o = addr_i[0];
        merged_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        load_o = {16'd0, word_i[{addr_i[1], 4'b0000} +: 16]};
      end
      default: begin
        misaligned_o = (addr_i != 2'd0);
        merged_o     = wdata_i;
        load_o       = word_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word memory with sub-word read-modify-write.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [1:0]               req0_size,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_rdata,
  output logic                     rsp0_err,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [1:0]               req1_size,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_rdata,
  output logic                     rsp1_err,
  output logic                     mem_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);

  state_t                   state_q, state_d;
  logic                     port_q, port_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
`ifdef DMEM_ARB_RR_EN
  logic                     last_grant_q, last_grant_d;
`endif

  logic                  grant0, grant1, handshake;
  logic [DATA_WIDTH-1:0] merged_word, load_word;
  logic                  misaligned;

  dmem_lane_merge u_lane_merge (
    .word_i       (mem_dout),
    .wdata_i      (wdata_q),
    .addr_i       (addr_q[1:0]),
    .size_i       (size_q),
    .merged_o     (merged_word),
    .load_o       (load_word),
    .misaligned_o (misaligned)
  );

  // Arbitration: a lone requester always wins; contention resolved by priority or rotation.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
`else
    grant1 = req1_valid && !req0_valid;
`endif
    grant0     = req0_valid && !grant1;
    req0_ready = (state_q == S_IDLE) && grant0;
    req1_ready = (state_q == S_IDLE) && grant1;
    handshake  = req0_ready || req1_ready;
  end

  always_comb begin
    mem_en     = (state_q == S_ACCESS) && we_q && !misaligned;
    mem_addr   = (state_q == S_ACCESS) ? {2'b00, addr_q[ADDRESS_WIDTH-1:2]} : '0;
    mem_din    = (state_q == S_ACCESS) ? merged_word : '0;
    rsp0_valid = (state_q == S_RESP) && !port_q;
    rsp1_valid = (state_q == S_RESP) && port_q;
    rsp0_rdata = rsp0_valid ? rdata_q : '0;
    rsp1_rdata = rsp1_valid ? rdata_q : '0;
    rsp0_err   = rsp0_valid && err_q;
    rsp1_err   = rsp1_valid && err_q;
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          port_d  = req1_ready;
          we_d    = req1_ready ? req1_we    : req0_we;
          size_d  = req1_ready ? req1_size  : req0_size;
          addr_d  = req1_ready ? req1_addr  : req0_addr;
          wdata_d = req1_ready ? req1_wdata : req0_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_ACCESS;
`ifdef DMEM_ARB_RR_EN
          last_grant_d = req1_ready;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        err_d   = misaligned;
        rdata_d = (!we_q && !misaligned) ? load_word : '0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset abandons any in-flight access; the write only happens at the ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
